// File: rtl/dspi_pkg.sv
// Shared definitions for the dual-SPI slave receive path.
//   BITS_PER_EDGE  : data bits captured on each SCLK rising edge
//   EDGES_PER_BYTE : SCLK rising edges that make one byte
//   dspi_state_e   : receive FSM states
//   dspi_entry_t   : stored byte layout {first, data[7:0]}
package dspi_pkg;

  localparam int BITS_PER_EDGE  = 2;
  localparam int EDGES_PER_BYTE = 4;
  localparam int CNT_W          = $clog2(EDGES_PER_BYTE);
  localparam int SH_W           = 8 - BITS_PER_EDGE;
  localparam int ENTRY_W        = 9;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } dspi_state_e;

  typedef struct packed {
    logic       first;
    logic [7:0] data;
  } dspi_entry_t;

endpackage

// File: rtl/dspi_rx_fifo.sv
// Synchronous byte FIFO for the dual-SPI receive path.
// Parameters: DEPTH (power of two, >= 2), WIDTH (entry width).
// Ports:
//   clk, reset (async, active-low)
//   push/push_data : write one entry (caller never pushes when full without popping)
//   pop            : discard head entry (caller never pops when empty)
//   pop_data       : current head entry, valid whenever empty=0
//   full, empty    : occupancy flags
module dspi_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // When full, a simultaneous push lands in the slot the pop frees.
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/dspi_slave_rx.sv
// Dual-SPI (2 data lines) slave receive engine.
// Oversamples io_sclk/io_ss/io_qd_read, captures 2 bits per SCLK rise (MSB
// first) and delivers bytes on a valid/ready stream tagged first-of-frame.
// Build option: define DSPI_RX_FIFO_EN to store bytes in a FIFO_DEPTH-entry
// FIFO; otherwise a single holding register is used.
// Ports:
//   clk, reset (async, active-low)
//   io_sclk, io_ss, io_qd_read[1:0] : asynchronous SPI pins
//   rx_data[7:0], rx_first, rx_valid, rx_ready : byte stream
//   frame_end    : one-cycle pulse when the frame closes
//   overflow     : sticky, a completed byte was dropped
//   overflow_clr : clears overflow
//
// state     | meaning
// ST_IDLE   | ss high, sclk ignored, waiting for ss fall
// ST_ACTIVE | frame open, shifting 2 bits per sclk rise
module dspi_slave_rx
  import dspi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_sclk,
  input  logic       io_ss,
  input  logic [1:0] io_qd_read,
  output logic [7:0] rx_data,
  output logic       rx_first,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_end,
  output logic       overflow,
  input  logic       overflow_clr
);

  if (!(SYNC_STAGES >= 2 && SYNC_STAGES <= 4 && FIFO_DEPTH >= 2 &&
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0)) begin : g_bad_cfg
    $error("dspi_slave_rx: illegal SYNC_STAGES or FIFO_DEPTH");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EDGES_PER_BYTE - 1);

  // ---------------------------------------------------------------
  // Synchronisers. qd uses the same depth as sclk so the data seen on
  // the detected edge is the data sampled alongside that edge.
  // ss resets to 0 so a frame already open at reset release is not
  // mistaken for a new one: only a genuine high->low transition counts.
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0]      sclk_sync;
  logic [SYNC_STAGES-1:0]      ss_sync;
  logic [SYNC_STAGES-1:0][1:0] qd_sync;
  logic                        sclk_hist;
  logic                        ss_hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      qd_sync   <= '0;
      sclk_hist <= 1'b0;
      ss_hist   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], io_sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], io_ss};
      qd_sync   <= {qd_sync[SYNC_STAGES-2:0], io_qd_read};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      ss_hist   <= ss_sync[SYNC_STAGES-1];
    end
  end

  logic       sclk_s;
  logic       ss_s;
  logic [1:0] qd_s;
  logic       sclk_rise;
  logic       ss_fall;
  logic       ss_rise;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign qd_s      = qd_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign ss_fall   = ~ss_s & ss_hist;
  assign ss_rise   = ss_s & ~ss_hist;

  // ---------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------
  dspi_state_e      state, state_nx;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nx;
  logic [SH_W-1:0]  shreg, shreg_nx;
  logic             first_pend, first_pend_nx;
  logic             frame_end_nx;
  logic             push;
  dspi_entry_t      push_entry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      first_pend <= 1'b0;
      frame_end  <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_cnt_nx;
      shreg      <= shreg_nx;
      first_pend <= first_pend_nx;
      frame_end  <= frame_end_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    bit_cnt_nx    = bit_cnt;
    shreg_nx      = shreg;
    first_pend_nx = first_pend;
    frame_end_nx  = 1'b0;
    push          = 1'b0;
    push_entry    = '0;
    case (state)
      ST_IDLE: begin
        if (ss_fall) begin
          state_nx      = ST_ACTIVE;
          bit_cnt_nx    = '0;
          first_pend_nx = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // ss rise wins over a coincident sclk rise; a partial byte is dropped.
        if (ss_rise) begin
          state_nx     = ST_IDLE;
          bit_cnt_nx   = '0;
          frame_end_nx = 1'b1;
        end else if (sclk_rise) begin
          shreg_nx   = {shreg[SH_W-BITS_PER_EDGE-1:0], qd_s};
          bit_cnt_nx = bit_cnt + 1'b1;
          if (bit_cnt == CNT_LAST) begin
            push             = 1'b1;
            push_entry.first = first_pend;
            push_entry.data  = {shreg, qd_s};
            first_pend_nx    = 1'b0;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Byte storage
  // ---------------------------------------------------------------
  logic pop;
  logic full;
  logic push_ok;
  logic ovf_set;

  assign pop     = rx_valid & rx_ready;
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

`ifdef DSPI_RX_FIFO_EN
  dspi_entry_t head;
  logic        fifo_empty;

  dspi_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_ok),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (fifo_empty)
  );

  assign rx_valid = ~fifo_empty;
  assign rx_data  = head.data;
  assign rx_first = head.first;
`else
  dspi_entry_t hold;
  logic        hold_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (push_ok) begin
      hold       <= push_entry;
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign full     = hold_valid;
  assign rx_valid = hold_valid;
  assign rx_data  = hold.data;
  assign rx_first = hold.first;
`endif

  // A new drop takes precedence over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            overflow <= 1'b0;
    else if (ovf_set)      overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_dspi_slave_rx.sv
module tb_dspi_slave_rx;

  localparam int FIFO_DEPTH = 4;
`ifdef DSPI_RX_FIFO_EN
  localparam int CAP = FIFO_DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       io_sclk;
  logic       io_ss;
  logic [1:0] io_qd_read;
  logic [7:0] rx_data;
  logic       rx_first;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_end;
  logic       overflow;
  logic       overflow_clr;

  always #5 clk = ~clk;

  dspi_slave_rx #(
    .SYNC_STAGES (2),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .io_sclk      (io_sclk),
    .io_ss        (io_ss),
    .io_qd_read   (io_qd_read),
    .rx_data      (rx_data),
    .rx_first     (rx_first),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_end    (frame_end),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         fe_cnt  = 0;
  int         cyc     = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  bit         rand_ready = 1'b0;
  logic       ready_fix  = 1'b1;
  logic       rnd_bit    = 1'b1;

  assign rx_ready = rand_ready ? rnd_bit : ready_fix;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Random consumer that is guaranteed to accept at least every 4th cycle.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1 rnd_bit = ($urandom_range(0, 1) == 1) || (cyc % 4 == 0);
  end

  // Monitor: every accepted beat is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (frame_end) fe_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_beat: got data %0h first %0b, none expected", rx_data, rx_first);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_data", {24'd0, rx_data}, {24'd0, mon_e[7:0]});
          chk("beat_first", {31'd0, rx_first}, {31'd0, mon_e[8]});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_edge(input logic [1:0] qd);
    io_qd_read = qd;
    tick(3);
    io_sclk = 1'b1;
    tick(3);
    io_sclk = 1'b0;
  endtask

  task automatic ss_low();
    io_ss = 1'b0;
    tick(4);
  endtask

  task automatic ss_high();
    tick(3);
    io_ss = 1'b1;
    tick(6);
  endtask

  // Master side: a byte goes out MSB first, two bits per rising edge.
  task automatic send_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) send_edge(2'((b >> (6 - 2 * k)) & 8'h03));
  endtask

  // Reference: every complete byte of a frame is delivered, only the first tagged,
  // unless the consumer stalls, in which case storage keeps the first CAP bytes.
  task automatic expect_frame(input logic [7:0] bytes[$], input bit stalled);
    for (int i = 0; i < bytes.size(); i++)
      if (!stalled || i < CAP) exp_q.push_back({(i == 0), bytes[i]});
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk({name, "_valid_after"}, {31'd0, rx_valid}, 32'd0);
  endtask

  initial begin
    logic [7:0] fr[$];
    int         fe0;
    int         nb;
    int         npart;

    io_sclk      = 1'b0;
    io_ss        = 1'b1;
    io_qd_read   = 2'b00;
    overflow_clr = 1'b0;
    #1 reset = 1'b0;
    tick(3);
    @(negedge clk);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_data", {24'd0, rx_data}, 32'd0);
    chk("rst_first", {31'd0, rx_first}, 32'd0);
    chk("rst_frame_end", {31'd0, frame_end}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b1;
    tick(6);

    // Explicit pair sequence 10,10,01,01 -> 0xA5
    fe0 = fe_cnt;
    exp_q.push_back({1'b1, 8'hA5});
    ss_low();
    send_edge(2'b10);
    send_edge(2'b10);
    send_edge(2'b01);
    send_edge(2'b01);
    ss_high();
    drain("t1");
    chk("t1_frame_end", fe_cnt - fe0, 1);
    chk("t1_overflow", {31'd0, overflow}, 32'd0);

    // Three-byte frame
    fr = '{8'h3C, 8'hFF, 8'h00};
    expect_frame(fr, 1'b0);
    ss_low();
    foreach (fr[i]) send_byte(fr[i]);
    ss_high();
    drain("t2");
    chk("t2_overflow", {31'd0, overflow}, 32'd0);

    // Stalled consumer: storage fills, the excess byte is dropped
`ifdef DSPI_RX_FIFO_EN
    fr = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
`else
    fr = '{8'h11, 8'h22};
`endif
    ready_fix = 1'b0;
    expect_frame(fr, 1'b1);
    ss_low();
    foreach (fr[i]) send_byte(fr[i]);
    ss_high();
    @(negedge clk);
    chk("stall_overflow", {31'd0, overflow}, 32'd1);
    chk("stall_valid", {31'd0, rx_valid}, 32'd1);
    tick(10);
    @(negedge clk);
    chk("stall_hold_data", {24'd0, rx_data}, {24'd0, fr[0]});
    chk("stall_hold_first", {31'd0, rx_first}, 32'd1);
    ready_fix = 1'b1;
    drain("t3");
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    tick(1);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);
    tick(2);

    // Partial byte then a fresh frame
    fe0 = fe_cnt;
    exp_q.push_back({1'b1, 8'h5A});
    ss_low();
    send_edge(2'b10);
    send_edge(2'b11);
    ss_high();
    ss_low();
    send_byte(8'h5A);
    ss_high();
    drain("t4");
    chk("t4_frame_end", fe_cnt - fe0, 2);

    // Reset in the middle of a byte
    ss_low();
    send_edge(2'b11);
    send_edge(2'b00);
    reset = 1'b0;
    tick(2);
    @(negedge clk);
    chk("t5_rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("t5_rst_frame_end", {31'd0, frame_end}, 32'd0);
    io_ss = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(6);
    fe0 = fe_cnt;
    exp_q.push_back({1'b1, 8'hC3});
    ss_low();
    send_byte(8'hC3);
    ss_high();
    drain("t5");
    chk("t5_frame_end", fe_cnt - fe0, 1);

    // Random frames, random trailing partial edges, jittery consumer
    rand_ready = 1'b1;
    fe0 = fe_cnt;
    for (int f = 0; f < 20; f++) begin
      nb = $urandom_range(1, 4);
      npart = $urandom_range(0, 3);
      fr.delete();
      for (int i = 0; i < nb; i++) fr.push_back(8'($urandom));
      expect_frame(fr, 1'b0);
      ss_low();
      foreach (fr[i]) send_byte(fr[i]);
      for (int p = 0; p < npart; p++) send_edge(2'($urandom));
      ss_high();
    end
    drain("rand");
    chk("rand_frame_end", fe_cnt - fe0, 20);
    chk("rand_overflow", {31'd0, overflow}, 32'd0);
    rand_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
